// File: rtl/interleave_sched_pkg.sv
// Shared types, default parameters and the round-robin pick helper for the
// interleave credit scheduler.
package interleave_sched_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_CREDIT_W   = 4;
  localparam int unsigned DEF_MAX_CREDIT = 8;
  localparam int unsigned MAX_REQ        = 16;
  localparam int unsigned PICK_W         = 4;

  typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} sched_state_e;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } rr_pick_t;

  // First set bit at or above ptr, else the lowest set bit overall (wraps the search).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid_vec,
                                       input logic [PICK_W-1:0]  ptr);
    rr_pick_t          hi;
    rr_pick_t          lo;
    logic [PICK_W-1:0] idx;
    hi = '0;
    lo = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      idx = PICK_W'(i);
      if (valid_vec[idx]) begin
        lo.found = 1'b1;
        lo.idx   = idx;
        if (idx >= ptr) begin
          hi.found = 1'b1;
          hi.idx   = idx;
        end
      end
    end
    return hi.found ? hi : lo;
  endfunction

endpackage

// File: rtl/interleave_credit_counter.sv
// Per-requester credit counter: load, saturating up/down, overflow and
// underflow flags.
module interleave_credit_counter
  import interleave_sched_pkg::*;
#(
  parameter int unsigned CREDIT_W   = DEF_CREDIT_W,
  parameter int unsigned MAX_CREDIT = DEF_MAX_CREDIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clken,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_val,
  input  logic [CREDIT_W-1:0] limit,
  input  logic                incr,
  input  logic                decr,
  output logic [CREDIT_W-1:0] count,
  output logic                is_zero,
  output logic                ovf_c,
  output logic                unf_c
);

  // Simultaneous incr and decr cancel; load overrides both.
  always_comb begin
    is_zero = (count == '0);
    ovf_c   = clken && !load && incr && !decr && (count >= limit);
    unf_c   = clken && !load && decr && !incr && (count == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= CREDIT_W'(MAX_CREDIT);
    end else if (load) begin
      count <= load_val;
    end else if (clken) begin
      if (incr && !decr && !ovf_c) begin
        count <= count + CREDIT_W'(1);
      end else if (decr && !incr && !unf_c) begin
        count <= count - CREDIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/interleave_credit_scheduler.sv
// Credit-based round-robin scheduler feeding one registered valid/ready slot
// of the interleave datapath.
module interleave_credit_scheduler
  import interleave_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned CREDIT_W   = DEF_CREDIT_W,
  parameter int unsigned MAX_CREDIT = DEF_MAX_CREDIT,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  req_ready,
  input  logic [NUM_REQ-1:0]  cr_return,
  input  logic                pause,
  input  logic                cfg_load,
  input  logic [CREDIT_W-1:0] cfg_credit,
  output logic                out_valid,
  output logic [ID_W-1:0]     out_id,
  input  logic                out_ready,
  output logic                idle,
  output logic                cr_err
);

  sched_state_e        state;
  sched_state_e        state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [CREDIT_W-1:0] lim;
  logic [CREDIT_W-1:0] credit [NUM_REQ];
  logic [NUM_REQ-1:0]  cnt_zero;
  logic [NUM_REQ-1:0]  ovf;
  logic [NUM_REQ-1:0]  unf;
  logic [NUM_REQ-1:0]  at_lim;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  accept;
  rr_pick_t            pick;
  logic                slot_free;
  logic                grant_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (pause)  state_nxt = PAUSED;
      PAUSED:  if (!pause) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Arbitration; the slot-free term lets a grant enter as the slot drains.
  always_comb begin
    eligible  = req_valid & ~cnt_zero;
    slot_free = !out_valid || out_ready;
    pick      = rr_pick(MAX_REQ'(eligible), PICK_W'(rr_ptr));
    grant_en  = !rst && (state == RUN) && slot_free && !cfg_load && pick.found;
    req_ready = grant_en ? (NUM_REQ'(1) << pick.idx) : '0;
    accept    = req_valid & req_ready;
    idle      = (state == PAUSED) && !out_valid && (&at_lim);
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    interleave_credit_counter #(
      .CREDIT_W   (CREDIT_W),
      .MAX_CREDIT (MAX_CREDIT)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clken    (1'b1),
      .load     (cfg_load),
      .load_val (cfg_credit),
      .limit    (lim),
      .incr     (cr_return[g]),
      .decr     (accept[g]),
      .count    (credit[g]),
      .is_zero  (cnt_zero[g]),
      .ovf_c    (ovf[g]),
      .unf_c    (unf[g])
    );
    assign at_lim[g] = (credit[g] == lim);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      rr_ptr    <= '0;
      cr_err    <= 1'b0;
      lim       <= CREDIT_W'(MAX_CREDIT);
    end else begin
      if (cfg_load) begin
        lim <= cfg_credit;
      end
      if ((|ovf) || (|unf)) begin
        cr_err <= 1'b1;
      end
      if (grant_en) begin
        out_valid <= 1'b1;
        out_id    <= ID_W'(pick.idx);
        rr_ptr    <= (pick.idx == PICK_W'(NUM_REQ - 1)) ? '0 : ID_W'(pick.idx + PICK_W'(1));
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_interleave_credit_scheduler.sv
// Scoreboard bench for interleave_credit_scheduler: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_interleave_credit_scheduler;

  localparam int N    = 4;
  localparam int CW   = 4;
  localparam int MAXC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  cr_return = '0;
  logic          pause = 1'b0;
  logic          cfg_load = 1'b0;
  logic [CW-1:0] cfg_credit = '0;
  logic          out_valid;
  logic [1:0]    out_id;
  logic          out_ready = 1'b0;
  logic          idle;
  logic          cr_err;

  interleave_credit_scheduler #(
    .NUM_REQ(N), .CREDIT_W(CW), .MAX_CREDIT(MAXC)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .cr_return(cr_return), .pause(pause), .cfg_load(cfg_load),
    .cfg_credit(cfg_credit), .out_valid(out_valid), .out_id(out_id),
    .out_ready(out_ready), .idle(idle), .cr_err(cr_err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int cred [N];
  int inflight [N];
  int lim;
  int ptr;
  bit m_paused;
  bit m_sv;
  int m_sid;
  bit m_err;
  bit run = 1'b0;
  int exp_q [$];
  int glog [$];
  int gcount [N];
  int gtotal = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      cred[i] = MAXC;
      inflight[i] = 0;
    end
    lim = MAXC;
    ptr = 0;
    m_paused = 1'b0;
    m_sv = 1'b0;
    m_sid = 0;
    m_err = 1'b0;
    exp_q.delete();
  endtask

  // Behavioural model: predict this cycle's outputs, then advance to the next edge.
  always @(negedge clk) begin
    int win;
    int j;
    logic [N-1:0] er;
    bit free;
    bit all_lim;
    bit a;
    bit r;
    if (run && !rst) begin
      free = !m_sv || out_ready;
      win = -1;
      if (!m_paused && free && !cfg_load) begin
        for (int k = 0; k < N; k++) begin
          j = (ptr + k) % N;
          if (win < 0 && req_valid[j] && cred[j] != 0) win = j;
        end
      end
      er = '0;
      if (win >= 0) er[win] = 1'b1;
      all_lim = 1'b1;
      for (int i = 0; i < N; i++) if (cred[i] != lim) all_lim = 1'b0;
      chk("req_ready", int'(req_ready), int'(er));
      chk("out_valid", int'(out_valid), int'(m_sv));
      if (m_sv) chk("out_id", int'(out_id), m_sid);
      chk("cr_err", int'(cr_err), int'(m_err));
      chk("idle", int'(idle), int'(m_paused && !m_sv && all_lim));
      if (cfg_load) begin
        lim = int'(cfg_credit);
        for (int i = 0; i < N; i++) begin
          cred[i] = lim;
          inflight[i] = 0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          a = (i == win);
          r = cr_return[i];
          inflight[i] = inflight[i] + (a ? 1 : 0) - (r ? 1 : 0);
          if (r && !a) begin
            if (cred[i] >= lim) m_err = 1'b1;
            else cred[i] = cred[i] + 1;
          end else if (a && !r) begin
            cred[i] = cred[i] - 1;
          end
        end
      end
      if (win >= 0) begin
        m_sv = 1'b1;
        m_sid = win;
        ptr = (win + 1) % N;
        exp_q.push_back(win);
      end else if (m_sv && out_ready) begin
        m_sv = 1'b0;
      end
      m_paused = pause;
    end
  end

  // Monitor: every output handshake must match the oldest predicted grant.
  always @(negedge clk) begin
    int e;
    if (run && !rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual_id=%0d expected=none t=%0t", out_id, $time);
      end else begin
        e = exp_q.pop_front();
        chk("grant_id", int'(out_id), e);
      end
      gcount[out_id]++;
      gtotal++;
      glog.push_back(int'(out_id));
    end
  end

  task automatic step(input logic [N-1:0] rv, input logic [N-1:0] crr,
                      input logic pz, input logic ordy);
    req_valid = rv;
    cr_return = crr;
    pause     = pz;
    out_ready = ordy;
    cfg_load  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [CW-1:0] val, input logic [N-1:0] rv,
                      input logic [N-1:0] crr, input logic pz);
    req_valid  = rv;
    cr_return  = crr;
    pause      = pz;
    out_ready  = 1'b1;
    cfg_load   = 1'b1;
    cfg_credit = val;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic return_all(input logic pz);
    logic [N-1:0] m;
    for (int t = 0; t < 20; t++) begin
      m = '0;
      for (int i = 0; i < N; i++) if (inflight[i] > 0) m[i] = 1'b1;
      if (m == '0) break;
      step('0, m, pz, 1'b1);
    end
  endtask

  initial begin
    int n0;
    int gb [N];
    logic pz;
    logic [N-1:0] crr;
    model_reset();
    for (int i = 0; i < N; i++) gcount[i] = 0;
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_id", int'(out_id), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_cr_err", int'(cr_err), 0);
    chk("rst_idle", int'(idle), 0);
    rst = 1'b0;
    run = 1'b1;

    // Round-robin fairness
    n0 = gtotal;
    repeat (8) step('1, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    chk("rr_count", gtotal - n0, 8);
    if (glog.size() >= n0 + 8)
      for (int k = 0; k < 8; k++) chk("rr_seq", glog[n0 + k], k % 4);
    return_all(1'b0);

    // Credit exhaustion then a single return
    n0 = gtotal;
    repeat (10) step(4'b0100, '0, 1'b0, 1'b1);
    chk("exhaust_ready", int'(req_ready[2]), 0);
    step('0, '0, 1'b0, 1'b1);
    chk("exhaust_grants", gtotal - n0, 8);
    step(4'b0100, 4'b0100, 1'b0, 1'b1);
    repeat (2) step(4'b0100, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    chk("return_regrant", gtotal - n0, 9);
    return_all(1'b0);

    // Backpressure with bypass release
    n0 = gtotal;
    repeat (4) step(4'b0010, '0, 1'b0, 1'b0);
    chk("bp_valid_held", int'(out_valid), 1);
    chk("bp_id_held", int'(out_id), 1);
    chk("bp_no_ready", int'(req_ready), 0);
    step(4'b0010, '0, 1'b0, 1'b1);
    repeat (2) step('0, '0, 1'b0, 1'b1);
    chk("bp_grants", gtotal - n0, 2);
    return_all(1'b0);

    // Accept and return together on requester 0 at full credit
    step(4'b0001, 4'b0001, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    chk("same_cycle_no_err", int'(cr_err), 0);

    // Randomized traffic
    pz = 1'b0;
    for (int c = 0; c < 500; c++) begin
      crr = '0;
      for (int i = 0; i < N; i++) if (inflight[i] > 0 && ($urandom % 3 == 0)) crr[i] = 1'b1;
      if ($urandom % 25 == 0) pz = ~pz;
      if ($urandom % 120 == 0) load(CW'($urandom_range(1, 15)), N'($urandom), N'($urandom), pz);
      else step(N'($urandom), crr, pz, ($urandom % 4) != 0);
    end
    step('0, '0, 1'b0, 1'b1);
    return_all(1'b0);

    // Pause drains the slot, idle after returns, then reload to 3
    step('1, '0, 1'b1, 1'b1);
    repeat (3) step('1, '0, 1'b1, 1'b1);
    chk("pause_drained", int'(out_valid), 0);
    return_all(1'b1);
    chk("idle_after_returns", int'(idle), 1);
    load(CW'(3), '0, '0, 1'b1);
    for (int i = 0; i < N; i++) gb[i] = gcount[i];
    repeat (16) step('1, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) chk("load_grants", gcount[i] - gb[i], 3);
    return_all(1'b0);

    // Overflow sets a sticky error
    step('0, 4'b0001, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    chk("overflow_err", int'(cr_err), 1);
    repeat (3) step('0, '0, 1'b0, 1'b1);
    chk("err_sticky", int'(cr_err), 1);

    // Asynchronous reset with a held grant
    repeat (2) step('1, '0, 1'b0, 1'b0);
    chk("pre_rst_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #2;
    chk("rst_async_valid", int'(out_valid), 0);
    chk("rst_async_err", int'(cr_err), 0);
    chk("rst_async_ready", int'(req_ready), 0);
    model_reset();
    req_valid = '1;
    out_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("post_rst_pick0", int'(req_ready), 1);
    @(posedge clk);
    #1;
    repeat (4) step('1, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
